// File: rtl/bist_pkg.sv
// bist_pkg: state encoding and MISR constants shared by the BIST analyzer and pattern generator.
package bist_pkg;
  typedef enum logic [1:0] {IDLE, RUN, CHECK, DONE} state_e;
  localparam logic [7:0] MISR_TAPS = 8'h33;
  localparam logic [7:0] MISR_SEED = 8'h00;
endpackage

// File: rtl/bist_misr.sv
// bist_misr: 8-bit multiple-input signature register, polynomial x^8+x^5+x^4+x+1.
module bist_misr
  import bist_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       clr,
  input  logic       en,
  input  logic [7:0] d,
  output logic [7:0] sig
);
  logic [7:0] sig_q, sig_d;
  always_comb sig_d = clr ? MISR_SEED
                    : en ? ({sig_q[6:0], 1'b0} ^ (sig_q[7] ? MISR_TAPS : 8'h00) ^ d)
                    : sig_q;
  always_ff @(posedge clk) begin
    if (reset) sig_q <= MISR_SEED;
    else       sig_q <= sig_d;
  end
  assign sig = sig_q;
endmodule

// File: rtl/bist_response_analyzer.sv
// bist_response_analyzer: compacts N_PATTERNS response beats into a MISR and compares against GOLDEN_SIG.
module bist_response_analyzer
  import bist_pkg::*;
#(
  parameter int unsigned N_PATTERNS = 255,
  parameter logic [7:0]  GOLDEN_SIG = 8'h00
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       resp_valid,
  input  logic [7:0] resp_data,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [7:0] signature
);
  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        pass_q, pass_d;
  logic        clr, fold, last;
  assign clr  = (state_q == IDLE || state_q == DONE) && start;
  assign fold = state_q == RUN && resp_valid;
  assign last = fold && cnt_q == 16'(N_PATTERNS - 1);
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    if (clr) begin
      state_d = RUN;
      cnt_d   = 16'd0;
      pass_d  = 1'b0;
    end else if (fold) begin
      cnt_d   = cnt_q + 16'd1;
      state_d = last ? CHECK : RUN;
    end else if (state_q == CHECK) begin
      pass_d  = signature == GOLDEN_SIG;
      state_d = DONE;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 16'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pass_q  <= pass_d;
    end
  end
  bist_misr u_misr (
    .clk  (clk),
    .reset(reset),
    .clr  (clr),
    .en   (fold),
    .d    (resp_data),
    .sig  (signature)
  );
  assign busy = state_q == RUN || state_q == CHECK;
  assign done = state_q == DONE;
  assign pass = pass_q;
endmodule
